// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// ============================================================================
// Module      : fa
// Description : Single-bit combinational full adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first through one full adder.
//               Optional subtract mode enabled by macro SERIAL_ADDER_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             op_sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int              c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;

    logic               w_accept;
    logic               w_last;
    logic               w_b_bit;
    logic               w_init_carry;
    logic               w_fa_sum;
    logic               w_fa_cout;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_last_cnt);

`ifdef SERIAL_ADDER_SUB_EN
    logic r_sub;
    // Two's-complement subtract: invert B into the adder and seed carry with 1.
    assign w_b_bit      = r_b_sh[0] ^ r_sub;
    assign w_init_carry = op_sub;
`else
    assign w_b_bit      = r_b_sh[0];
    assign w_init_carry = 1'b0;
`endif

    fa u_fa (
        .a     (r_a_sh[0]),
        .b     (w_b_bit),
        .c_in  (r_carry),
        .sum   (w_fa_sum),
        .c_out (w_fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == c_last_cnt) w_next_state = S_DONE;
            S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Flags are registered from the next state so they align with r_state.
    always_comb begin
        w_busy_nxt = (w_next_state == S_RUN);
        w_done_nxt = (w_next_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= w_busy_nxt;
            done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_cnt   <= '0;
            r_carry <= w_init_carry;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= op_sub;
`endif
        end else if (r_state == S_RUN) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            sum     <= {w_fa_sum, sum[WIDTH-1:1]};
            if (w_last) begin
                c_out <= w_fa_cout;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic       op_sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;

    int n_checks;
    int n_errors;

    serial_adder #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef SERIAL_ADDER_SUB_EN
        .op_sub (op_sub),
`endif
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .c_out  (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start request for one cycle; returns just after the accept edge.
    task automatic launch(input string tag, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_at_accept"}, busy, 1'b1);
        check({tag, "_done_at_accept"}, done, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int exp_cyc,
                             input logic [7:0] es, input logic ec);
        int cyc;
        int bc;
        cyc = 0;
        bc  = 0;
        while (!done && cyc < 30) begin
            if (busy) bc++;
            tick();
            cyc++;
        end
        check({tag, "_done"},    done,  1'b1);
        check({tag, "_latency"}, cyc,   exp_cyc);
        check({tag, "_busycnt"}, bc,    exp_cyc);
        check({tag, "_busy_lo"}, busy,  1'b0);
        check({tag, "_sum"},     sum,   es);
        check({tag, "_cout"},    c_out, ec);
    endtask

    initial begin
        int ndone;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        op_sub = 1'b0;
`endif
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum",  sum,  8'h00);
        check("rst_cout", c_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        launch("add5a3c", 8'h5A, 8'h3C);
        wait_done("add5a3c", 8, 8'h96, 1'b0);
        tick();
        check("add5a3c_done_pulse", done, 1'b0);

        launch("addff01", 8'hFF, 8'h01);
        wait_done("addff01", 8, 8'h00, 1'b1);

        launch("addffff", 8'hFF, 8'hFF);
        wait_done("addffff", 8, 8'hFE, 1'b1);

        // Start during the DONE cycle runs back-to-back.
        launch("b2b8080", 8'h80, 8'h80);
        wait_done("b2b8080", 8, 8'h00, 1'b1);
        tick();
        check("b2b_done_pulse", done, 1'b0);

        // A start pulse during RUN must be dropped.
        launch("ign1020", 8'h10, 8'h20);
        tick();
        tick();
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign1020", 5, 8'h30, 1'b0);
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done) ndone++;
        end
        check("ign_extra_done", ndone, 0);
        check("ign_sum_hold", sum, 8'h30);

        // Asynchronous reset mid-RUN.
        launch("rst1234", 8'h12, 8'h34);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_sum",  sum,  8'h00);
        check("midrst_cout", c_out, 1'b0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("midrst_quiet", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        launch("add0102", 8'h01, 8'h02);
        wait_done("add0102", 8, 8'h03, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        tick();
        op_sub = 1'b1;
        launch("sub1020", 8'h10, 8'h20);
        wait_done("sub1020", 8, 8'hF0, 1'b0);
        launch("sub2010", 8'h20, 8'h10);
        wait_done("sub2010", 8, 8'h10, 1'b1);
        op_sub = 1'b0;
        launch("addafter", 8'h20, 8'h10);
        wait_done("addafter", 8, 8'h30, 1'b0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that sits directly behind the single-bit `fa` full adder. It latches two operands on `start` and feeds one bit pair per clock, LSB first, through one `fa` instance. A carry flip-flop closes the loop, and the sum shifts in MSB-first into a result register. The result is ready after WIDTH cycles and is signalled with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: operand/result width in bits, ≥2.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when state is IDLE or DONE.
- `a` in WIDTH: operand A, captured on accepted `start`.
- `b` in WIDTH: operand B, captured on accepted `start`.
- `op_sub` in 1: subtract select, captured on accepted `start`. Only present with `SERIAL_ADDER_SUB_EN`.
- `busy` out 1: high while bits are being processed.
- `done` out 1: one-cycle pulse when `sum`/`c_out` become valid.
- `sum` out WIDTH: result register.
- `c_out` out 1: final carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- **Accepting `start`** (in IDLE or DONE):
  - load `a` and `b` into shift registers;
  - clear the bit counter;
  - carry register ← 0 (← 1 for subtract);
  - go to RUN.
- **`start` outside IDLE/DONE**: ignored while RUN; it is not queued.
- **Each RUN cycle**:
  - drive `fa` with `a_sh[0]`, `b_sh[0]` (inverted for subtract) and the carry register;
  - carry register ← `fa.c_out`;
  - `sum` ← {`fa.sum`, `sum[WIDTH-1:1]`};
  - shift `a_sh` and `b_sh` right by one;
  - counter += 1.
- **RUN → DONE** when the counter reaches WIDTH-1 on a RUN edge, i.e. after exactly WIDTH RUN cycles. On that same edge, `c_out` ← final `fa.c_out`.
- **DONE → IDLE** unconditionally, unless `start` is asserted, in which case DONE → RUN as a new operation.
- **Arithmetic**: `{c_out, sum}` = `a + b` modulo 2^(WIDTH+1). The carry chain is identical to a ripple adder.
- **`sum` validity**:
  - during RUN it holds a partially shifted value and is not valid;
  - it is valid from the `done` cycle and holds until the next accepted `start`.
- **Reset** (asserted any time, including mid-RUN): state → IDLE. `busy`=0, `done`=0, `sum`=0, `c_out`=0, carry register=0, counter=0, and shift registers=0. The in-flight operation is discarded, with no `done`.

## Timing
- Start accepted at edge k: `busy`=1 from edge k through edge k+WIDTH−1.
- Edge k+WIDTH: `busy`=0, `done`=1, and `sum`/`c_out` are valid.
- Edge k+WIDTH+1: `done`=0.
- Latency from `start` to `done` is WIDTH+1 cycles including the accept cycle. Throughput is one operation per WIDTH+1 cycles when `start` is reasserted during DONE.
- `busy` and `done` are never high together.
- All outputs are registered; the only combinational path is through `fa`, which is internal.
- The counter is $clog2(WIDTH) bits wide and has no wrap-around; the RUN exit is decoded at WIDTH-1.

## Configuration
- **`SERIAL_ADDER_SUB_EN` defined**:
  - adds the `op_sub` port;
  - when `op_sub`=1 is captured, the B bit is inverted into `fa` and the initial carry is 1, giving `sum` = `a − b` mod 2^WIDTH;
  - `c_out` = 1 means no borrow (a ≥ b unsigned).
- **`SERIAL_ADDER_SUB_EN` undefined**: no `op_sub` port, initial carry is always 0, add only.

## Structure
- `serial_adder_pkg`:
  - state typedef (IDLE/RUN/DONE encodings: 2'b00/2'b01/2'b10);
  - localparam for the default width.
- One sub-module: `fa` (single-bit full adder), one instance, combinational. It is the only arithmetic in the block.
- The top module holds the FSM, counter, operand shift registers, carry flip-flop and result register.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `start` one cycle → `done` pulses 9 cycles after the start edge, `sum`=0x96, `c_out`=0, and `busy` is high for exactly 8 cycles.
- `a`=0xFF, `b`=0x01 → `sum`=0x00, `c_out`=1. Then `a`=0xFF, `b`=0xFF → `sum`=0xFE, `c_out`=1.
- Pulse `start` again with `a`=0x01, `b`=0x01 at the 3rd RUN cycle of an op on 0x10+0x20 → ignored. Result is `sum`=0x30, only one `done`.
- Assert `rst_n`=0 mid-RUN of 0x12+0x34 → all outputs 0 immediately, no `done`. After release, a new 0x01+0x02 gives `sum`=0x03.
- Assert `start` during the `done` cycle with 0x80+0x80 → next op runs back-to-back, `done` 9 cycles later, `sum`=0x00, `c_out`=1.
- With `SERIAL_ADDER_SUB_EN`:
  - `op_sub`=1, 0x10−0x20 → `sum`=0xF0, `c_out`=0;
  - `op_sub`=1, 0x20−0x10 → `sum`=0x10, `c_out`=1.
